count_job_arbiter: RTL

- Controller and round-robin arbiter that shares the single 9-bit enable counter (clk, en, reset, count) between two requesters.
- Each requester asks for a "count-to-N" job.
- The block grants one requester, clears the counter, drives its enable until the count reaches the latched target, then signals completion and releases the counter.
- It sits between the requester logic and the counter instance at top level.

---
 rtl/count_job_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/count_job_arbiter.sv
// Round-robin owner of a shared enable counter: grants one of two requesters,
// clears the counter, enables it up to the latched target, then pulses done.
module count_job_arbiter #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] target0,
   input  logic [WIDTH-1:0] target1,
   input  logic [WIDTH-1:0] count_in,
   output logic             cnt_en,
   output logic             cnt_rst,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy
);

   // Handshake: req[i] is a level held until done[i] or withdrawal; dropping it
   // while granted aborts the job without a done pulse.
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DONE, ABORT} state_t;

   state_t           state, state_nxt;
   logic             g, g_nxt;
   logic             prio;
   logic [WIDTH-1:0] target_q;
   logic             req_g;
   logic             match;
   logic [1:0]       gnt_d;
   logic [1:0]       done_d;
   logic             cnt_rst_d;

   assign req_g = req[g];
   assign match = (count_in == target_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         g     <= 1'b0;
      end else begin
         state <= state_nxt;
         g     <= g_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      g_nxt     = g;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = CLEAR;
               g_nxt     = (req == 2'b11) ? prio : req[1];
            end
         end
         CLEAR:   state_nxt = req_g ? RUN : ABORT;
         // Withdrawal wins over a simultaneous target match.
         RUN: begin
            if (!req_g)     state_nxt = ABORT;
            else if (match) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         ABORT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_en    = (state == RUN) && req_g && !match;
      busy      = (state != IDLE);
      gnt_d     = 2'b00;
      done_d    = 2'b00;
      cnt_rst_d = (state_nxt == CLEAR);
      if (state_nxt == CLEAR || state_nxt == RUN) gnt_d = {g_nxt, ~g_nxt};
      if (state_nxt == DONE) done_d = {g, ~g};
   end

   // Registered outputs are derived from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt      <= 2'b00;
         done     <= 2'b00;
         cnt_rst  <= 1'b0;
         prio     <= 1'b0;
         target_q <= '0;
      end else begin
         gnt     <= gnt_d;
         done    <= done_d;
         cnt_rst <= cnt_rst_d;
         if (state == IDLE && (|req)) target_q <= g_nxt ? target1 : target0;
         if (state_nxt == DONE || state_nxt == ABORT) prio <= ~g;
      end
   end

endmodule
